// File: rtl/vga_pixel_pipe_if.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipe_if
// Icon position update channel between a requester (master) and the pixel
// pipe (slave).
//   posX   [9:0]  requested icon left column
//   posY   [9:0]  requested icon top line
//   posReq        request, held with posX/posY stable until posAck
//   posAck        one-cycle commit acknowledge from the pipe
//
// Handshake: the master raises posReq with posX/posY and holds all three
// until it sees posAck. The slave samples posReq only on its commit cycle
// (first pixel of vertical blanking) and answers with a single-cycle posAck
// on the edge that loads the new position. Dropping posReq before the commit
// cycle withdraws the request silently. posReq still high the cycle after
// posAck counts as a fresh request for the following frame.
// ---------------------------------------------------------------------------
interface vga_pixel_pipe_if;
    logic [9:0] posX;
    logic [9:0] posY;
    logic       posReq;
    logic       posAck;

    modport master (
        output posX,
        output posY,
        output posReq,
        input  posAck
    );

    modport slave (
        input  posX,
        input  posY,
        input  posReq,
        output posAck
    );
endinterface

// File: rtl/vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipe
// Pixel stage behind the VGA timing controller. Reads a 160x120 RGB444
// framebuffer (each entry shown as a 4x4 block), overlays a 16x16 icon with a
// transparent key colour and drives RGB plus syncs through a fixed 3-cycle
// pipeline so colour and syncs stay aligned.
//
// Ports:
//   ckVideo, rstVideo_n    pixel clock, async active-low reset
//   adrHor, adrVer         pixel coordinates from the timing controller
//   flgActiveVideo         visible-area flag
//   HS, VS                 controller syncs (active-low)
//   fbAddr / fbData        framebuffer read port, data one cycle after addr
//   iconAddr / iconData    icon ROM read port, data one cycle after addr
//   pos                    icon position req/ack channel (slave side)
//   vgaRed/Green/Blue      pixel colour
//   vgaHS, vgaVS           syncs aligned with the colour
//   dbgState               position handshake FSM state
// ---------------------------------------------------------------------------
module vga_pixel_pipe #(
    parameter int          cstHorActive   = 640,
    parameter int          cstVerActive   = 480,
    parameter logic [11:0] cstTransparent = 12'hF0F
) (
    input  logic               ckVideo,
    input  logic               rstVideo_n,
    input  logic [9:0]         adrHor,
    input  logic [9:0]         adrVer,
    input  logic               flgActiveVideo,
    input  logic               HS,
    input  logic               VS,
    output logic [14:0]        fbAddr,
    input  logic [11:0]        fbData,
    output logic [7:0]         iconAddr,
    input  logic [11:0]        iconData,
    vga_pixel_pipe_if.slave    pos,
    output logic [3:0]         vgaRed,
    output logic [3:0]         vgaGreen,
    output logic [3:0]         vgaBlue,
    output logic               vgaHS,
    output logic               vgaVS,
    output logic [0:0]         dbgState
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    localparam logic [9:0] cstHorLimit = 10'(cstHorActive);
    localparam logic [9:0] cstVerLine  = 10'(cstVerActive);

    // Handshake / icon position state
    logic [0:0]  r_state;
    logic        r_posAck;
    logic [9:0]  r_actX;
    logic [9:0]  r_actY;
    logic        r_iconEn;

    // Pipeline registers
    logic [14:0] r_fbAddr;
    logic [7:0]  r_iconAddr;
    logic        r_hit1, r_act1, r_hs1, r_vs1;
    logic        r_hit2, r_act2, r_hs2, r_vs2;
    logic [11:0] r_rgb;
    logic        r_hs3, r_vs3;

    logic        w_commitCycle;
    logic [7:0]  w_fbX;
    logic [7:0]  w_fbY;
    logic [14:0] w_fbAddr;
    logic [10:0] w_hor11, w_ver11, w_x0, w_y0, w_x1, w_y1;
    logic        w_hit;
    logic [3:0]  w_iconCol, w_iconRow;

    assign w_commitCycle = (adrHor == 10'd0) && (adrVer == cstVerLine);

    // Horizontal blanking coordinates are folded to column 0 so the address
    // never leaves the 160-wide buffer row.
    assign w_fbX    = (adrHor < cstHorLimit) ? adrHor[9:2] : 8'd0;
    assign w_fbY    = adrVer[9:2];
    // y*160 as (y<<7)+(y<<5)
    assign w_fbAddr = {w_fbY, 7'b0} + {2'b0, w_fbY, 5'b0} + {7'b0, w_fbX};

    // 11-bit compare so an icon near column 1023 clips instead of wrapping.
    assign w_hor11 = {1'b0, adrHor};
    assign w_ver11 = {1'b0, adrVer};
    assign w_x0    = {1'b0, r_actX};
    assign w_y0    = {1'b0, r_actY};
    assign w_x1    = w_x0 + 11'd16;
    assign w_y1    = w_y0 + 11'd16;
    assign w_hit   = r_iconEn && (w_hor11 >= w_x0) && (w_hor11 < w_x1)
                              && (w_ver11 >= w_y0) && (w_ver11 < w_y1);

    // Only the low nibble of the offset is needed inside a 16x16 box.
    assign w_iconCol = adrHor[3:0] - r_actX[3:0];
    assign w_iconRow = adrVer[3:0] - r_actY[3:0];

    // Position handshake: commit only on the first pixel of vertical blanking
    // so the visible frame always uses one position.
    always_ff @(posedge ckVideo or negedge rstVideo_n) begin
        if (!rstVideo_n) begin
            r_state  <= ST_IDLE;
            r_posAck <= 1'b0;
            r_actX   <= 10'd0;
            r_actY   <= 10'd0;
            r_iconEn <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_commitCycle && pos.posReq) begin
                        r_state  <= ST_COMMIT;
                        r_posAck <= 1'b1;
                        r_actX   <= pos.posX;
                        r_actY   <= pos.posY;
                        r_iconEn <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state  <= ST_IDLE;
                    r_posAck <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_posAck <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: addresses out, hit/act/syncs captured.
    // Stage 2: memories return data, control delayed to match.
    // Stage 3: colour select and registered outputs.
    always_ff @(posedge ckVideo or negedge rstVideo_n) begin
        if (!rstVideo_n) begin
            r_fbAddr   <= 15'd0;
            r_iconAddr <= 8'd0;
            r_hit1     <= 1'b0;
            r_act1     <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_hit2     <= 1'b0;
            r_act2     <= 1'b0;
            r_hs2      <= 1'b1;
            r_vs2      <= 1'b1;
            r_rgb      <= 12'd0;
            r_hs3      <= 1'b1;
            r_vs3      <= 1'b1;
        end else begin
            r_fbAddr   <= w_fbAddr;
            r_iconAddr <= {w_iconRow, w_iconCol};
            r_hit1     <= w_hit;
            r_act1     <= flgActiveVideo;
            r_hs1      <= HS;
            r_vs1      <= VS;

            r_hit2     <= r_hit1;
            r_act2     <= r_act1;
            r_hs2      <= r_hs1;
            r_vs2      <= r_vs1;

            if (!r_act2) begin
                r_rgb <= 12'd0;
            end else if (r_hit2 && (iconData != cstTransparent)) begin
                r_rgb <= iconData;
            end else begin
                r_rgb <= fbData;
            end
            r_hs3 <= r_hs2;
            r_vs3 <= r_vs2;
        end
    end

    assign fbAddr     = r_fbAddr;
    assign iconAddr   = r_iconAddr;
    assign pos.posAck = r_posAck;
    assign vgaRed     = r_rgb[11:8];
    assign vgaGreen   = r_rgb[7:4];
    assign vgaBlue    = r_rgb[3:0];
    assign vgaHS      = r_hs3;
    assign vgaVS      = r_vs3;
    assign dbgState   = r_state;

endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Downstream pixel stage for the VGA timing controller. It consumes the controller's pixel coordinates, active-video flag and syncs, and reads a 160×120 RGB444 framebuffer through a synchronous RAM port, with each framebuffer pixel shown as a 4×4 screen block. It overlays a 16×16 icon whose position is updated through a req/ack handshake that commits only at the start of vertical blanking. It drives the VGA pins with RGB and syncs aligned over a fixed 3-cycle pipeline.

## Interface
Parameters:
- cstHorActive, 640, visible pixels per line
- cstVerActive, 480, visible lines per frame
- cstTransparent, 12'hF0F, icon colour treated as transparent

Ports:
- ckVideo  in  1  pixel clock
- rstVideo_n  in  1  reset, asynchronous, active-low
- adrHor  in  10  horizontal pixel count from timing controller
- adrVer  in  10  vertical line count from timing controller
- flgActiveVideo  in  1  high inside visible area
- HS  in  1  horizontal sync from controller, active-low
- VS  in  1  vertical sync from controller, active-low
- fbAddr  out  15  framebuffer read address
- fbData  in  12  framebuffer RGB444 {R,G,B}, valid the cycle after fbAddr
- iconAddr  out  8  icon ROM address, {row[3:0], col[3:0]}
- iconData  in  12  icon ROM RGB444, valid the cycle after iconAddr
- posX  in  10  requested icon left column
- posY  in  10  requested icon top line
- posReq  in  1  position update request
- posAck  out  1  one-cycle commit acknowledge
- vgaRed, vgaGreen, vgaBlue  out  4 each  pixel colour
- vgaHS, vgaVS  out  1 each  aligned syncs, active-low

## Operation
Reset (asynchronous assert, synchronous release) sets these values:
- vgaRed/Green/Blue = 0
- vgaHS = vgaVS = 1
- posAck = 0, fbAddr = 0, iconAddr = 0
- actX = actY = 0
- iconEn = 0, so no icon is shown until the first commit.

Framebuffer address:
- fbAddr = (adrVer>>2)*160 + (adrHor>>2).
- Multiply implemented as (y<<7)+(y<<5), 15-bit result. The maximum is 19199, so there is no overflow.
- Outside the active area the address is don't-care but must stay within 15 bits.

Icon hit test (stage 1, 11-bit unsigned arithmetic, no wrap):
- hit = iconEn && adrHor ≥ actX && adrHor < actX+16 && adrVer ≥ actY && adrVer < actY+16.
- iconAddr = {(adrVer−actY)[3:0], (adrHor−actX)[3:0]}. It is don't-care when hit = 0.
- An icon at actX = 1020 is clipped to columns 1020..1023. It must not alias to column 0.

Colour select (stage 3):
- act = 0 → RGB = 0.
- act = 1, hit = 1 and iconData ≠ cstTransparent → RGB = iconData.
- Otherwise → RGB = fbData.

Position handshake, two-state FSM:
- IDLE → COMMIT when posReq = 1 on the commit cycle. The commit cycle is adrHor == 0 && adrVer == cstVerActive.
- In COMMIT: actX ← posX, actY ← posY, iconEn ← 1, posAck = 1 for exactly one cycle, then return to IDLE.
- The requester holds posReq and posX/posY stable until posAck. posReq is sampled only on the commit cycle.
- A request withdrawn before the commit cycle is ignored and produces no ack.
- posReq still high on the cycle after posAck is treated as a new request for the next frame.
- Committed position is used from the next frame onward. It never changes mid-frame.
- Reset during a pending request discards the request. The requester must re-present it.

## Timing
Pipeline stages for inputs sampled on edge N:
- Stage 1 (registered at N+1): fbAddr, iconAddr, hit, act, HS, VS.
- Stage 2 (N+2): RAM/ROM data returns. hit, act and syncs are delayed one more stage.
- Stage 3 (N+3): RGB, vgaHS and vgaVS registered.

Latency and alignment:
- Total latency is 3 cycles for RGB, vgaHS and vgaVS alike. All outputs are registered.
- Input pixel (x, y) appears on the outputs exactly 3 cycles after the timing controller presents it. Syncs keep their relative alignment to pixel data.

Handshake timing:
- posAck is asserted the cycle after the commit cycle.
- actX/actY change on the same edge that posAck rises.

## Test plan
- Reset release, all-blue framebuffer (fbData = 12'h00F), no request → the active area shows 12'h00F with 3-cycle latency; blanking shows 0; vgaHS/vgaVS equal HS/VS delayed 3 cycles.
- Address check: adrHor = 639, adrVer = 479 → fbAddr = 19199 one cycle later; adrHor = 5, adrVer = 9 → fbAddr = 321.
- posX = 100, posY = 50, posReq held → posAck pulses once, the cycle after adrVer = 480, adrHor = 0. Next frame: iconAddr = 8'h00 at (100, 50) and 8'hFF at (115, 65); icon colour appears only inside that box.
- Icon pixel equal to 12'hF0F inside the box → framebuffer colour shown; any other icon pixel → iconData shown.
- posReq pulsed high, then dropped before line 480 → no posAck; the icon position is unchanged.
- Assert rstVideo_n low mid-frame while a request is pending → outputs go to their reset values immediately; no posAck; the icon stays hidden after release until a new request commits.
